// File: rtl/angle_combination_evaluate.sv
// angle_combination_evaluate: walks the angle memory, sums the cosine of every entry through
// external trig/adder units and returns the mean as a float.
module angle_combination_evaluate #(
   parameter int EXP_LEN = 8,
   parameter int MANTISSA_LEN = 23,
   parameter int NUM_ANGLE_COMB = 8,
   localparam int W = EXP_LEN + MANTISSA_LEN + 1,
   localparam int AW = $clog2(NUM_ANGLE_COMB)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          evaluate_start,
   output logic [AW-1:0] mem_angle_combination_value_addr,
   input  logic [W-1:0]  mem_angle_combination_value_datao,
   output logic          cos_start,
   output logic [W-1:0]  cos_angle,
   input  logic [W-1:0]  cos_result,
   input  logic          cos_ready,
   output logic          add_start,
   output logic [W-1:0]  add_a,
   output logic [W-1:0]  add_b,
   input  logic [W-1:0]  add_sum,
   input  logic          add_ready,
   output logic          evaluate_done,
   output logic [W-1:0]  evaluate_result
);
   typedef enum logic [2:0] {IDLE, ADDR, READ, COS_REQ, COS_WAIT, ADD_REQ, ADD_WAIT, FINISH} state_t;
   state_t state_q, state_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [W-1:0] acc_q, acc_d, angle_q, angle_d, a_q, a_d, b_q, b_d, res_q, res_d, mean;
   logic done_q, done_d;
   logic [EXP_LEN-1:0] acc_exp;
   assign acc_exp = acc_q[W-2 -: EXP_LEN];
   // divide by a power of two by lowering the exponent; underflow flushes to +0.0
   assign mean = &acc_exp ? acc_q
               : (acc_exp > EXP_LEN'(AW)) ? {acc_q[W-1], acc_exp - EXP_LEN'(AW), acc_q[MANTISSA_LEN-1:0]}
               : '0;
   assign mem_angle_combination_value_addr = idx_q;
   assign cos_start       = state_q == COS_REQ;
   assign cos_angle       = angle_q;
   assign add_start       = state_q == ADD_REQ;
   assign add_a           = a_q;
   assign add_b           = b_q;
   assign evaluate_done   = done_q;
   assign evaluate_result = res_q;
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         acc_q   <= '0;
         angle_q <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         acc_q   <= acc_d;
         angle_q <= angle_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         done_q  <= done_d;
      end
   end
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      acc_d   = acc_q;
      angle_d = angle_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: if (evaluate_start && !done_q) begin
            state_d = ADDR;
            acc_d   = '0;
            idx_d   = '0;
         end
         ADDR: state_d = READ;
         READ: begin
            angle_d = mem_angle_combination_value_datao;
            state_d = COS_REQ;
         end
         COS_REQ: state_d = COS_WAIT;
         COS_WAIT: if (cos_ready) begin
            a_d     = acc_q;
            b_d     = cos_result;
            state_d = ADD_REQ;
         end
         ADD_REQ: state_d = ADD_WAIT;
         ADD_WAIT: if (add_ready) begin
            acc_d   = add_sum;
            state_d = (idx_q == AW'(NUM_ANGLE_COMB - 1)) ? FINISH : ADDR;
            idx_d   = (idx_q == AW'(NUM_ANGLE_COMB - 1)) ? idx_q : idx_q + AW'(1);
         end
         FINISH: begin
            res_d   = mean;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
endmodule
